// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: req/ack fetch FSM, DEPTH-entry prefetch FIFO and a registered decode output.
// Optional macro FETCH_BYPASS_EN sends an acked word straight to the output register when the FIFO is empty.
module if_prefetch_stage #(
    parameter int             N        = 32,
    parameter int             DEPTH    = 4,
    parameter logic [N-1:0]   RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     freezeIn,
    input  logic                     branchTakenIn,
    input  logic [N-1:0]             branchAddrIn,
    output logic                     imemReqOut,
    output logic [N-1:0]             imemAddrOut,
    input  logic                     imemAckIn,
    input  logic [N-1:0]             imemDataIn,
    output logic                     validOut,
    output logic [N-1:0]             instructionOut,
    output logic [N-1:0]             PCOut,
    output logic [$clog2(DEPTH):0]   fifoCountOut,
    output logic [1:0]               fetch_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    // Handshake: imemReqOut is high in WAIT and DRAIN and imemAddrOut is stable for that
    // whole time; a cycle with imemReqOut=1 and imemAckIn=1 completes the one outstanding request.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   fetch_pc, fetch_pc_nxt;
    logic [N-1:0]   target_q, target_nxt;
    logic [N-1:0]   branch_tgt, pc_plus4;
    logic           accept, bypass, push, pop, fifo_empty;

    logic [N-1:0]   fifo_data [DEPTH];
    logic [N-1:0]   fifo_pc   [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;

    logic           unused_addr_lsbs;
    assign unused_addr_lsbs = ^branchAddrIn[1:0];

    assign branch_tgt = {branchAddrIn[N-1:2], 2'b00};
    assign pc_plus4   = fetch_pc + N'(4);
    assign fifo_empty = (count == '0);

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        target_nxt   = target_q;
        accept       = 1'b0;
        case (state)
            S_IDLE: begin
                if (branchTakenIn)
                    fetch_pc_nxt = branch_tgt;
                else if (count < FULL)
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (branchTakenIn) begin
                    if (imemAckIn) begin
                        fetch_pc_nxt = branch_tgt;
                        state_nxt    = S_IDLE;
                    end else begin
                        target_nxt = branch_tgt;
                        state_nxt  = S_DRAIN;
                    end
                end else if (imemAckIn) begin
                    accept       = 1'b1;
                    fetch_pc_nxt = pc_plus4;
                    state_nxt    = S_IDLE;
                end
            end
            S_DRAIN: begin
                // The stale word is dropped; a branch in the same cycle wins over the latched target.
                if (imemAckIn) begin
                    fetch_pc_nxt = branchTakenIn ? branch_tgt : target_q;
                    state_nxt    = S_IDLE;
                end else if (branchTakenIn) begin
                    target_nxt = branch_tgt;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef FETCH_BYPASS_EN
    assign bypass = accept && fifo_empty && !freezeIn;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept && !bypass;
    assign pop  = !branchTakenIn && !freezeIn && !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            fetch_pc <= {RESET_PC[N-1:2], 2'b00};
            target_q <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            target_q <= target_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || branchTakenIn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= imemDataIn;
                fifo_pc[wr_ptr]   <= pc_plus4;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Output register: cleared by branch, held by freeze, otherwise refilled or emptied every cycle.
    always_ff @(posedge clk) begin
        if (rst || branchTakenIn) begin
            validOut       <= 1'b0;
            instructionOut <= '0;
            PCOut          <= '0;
        end else if (!freezeIn) begin
            if (pop) begin
                validOut       <= 1'b1;
                instructionOut <= fifo_data[rd_ptr];
                PCOut          <= fifo_pc[rd_ptr];
            end else if (bypass) begin
                validOut       <= 1'b1;
                instructionOut <= imemDataIn;
                PCOut          <= pc_plus4;
            end else begin
                validOut       <= 1'b0;
                instructionOut <= '0;
                PCOut          <= '0;
            end
        end
    end

    assign imemReqOut   = (state != S_IDLE);
    assign imemAddrOut  = fetch_pc;
    assign fifoCountOut = count;
    assign fetch_state  = state;

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: directed vector table, hand-written corner sequences and an expected-word queue.
module tb_if_prefetch_stage;

    logic        clk, rst;
    logic        freezeIn, branchTakenIn, imemAckIn;
    logic [31:0] branchAddrIn, imemDataIn;
    logic        imemReqOut, validOut;
    logic [31:0] imemAddrOut, instructionOut, PCOut;
    logic [2:0]  fifoCountOut;
    logic [1:0]  fetch_state;

    logic        w_ack, w_req, w_valid;
    logic [31:0] w_data, w_addr, w_instr, w_pc;
    logic [2:0]  w_cnt;
    logic [1:0]  w_state;

    if_prefetch_stage #(.N(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .rst(rst), .freezeIn(freezeIn), .branchTakenIn(branchTakenIn),
        .branchAddrIn(branchAddrIn), .imemReqOut(imemReqOut), .imemAddrOut(imemAddrOut),
        .imemAckIn(imemAckIn), .imemDataIn(imemDataIn), .validOut(validOut),
        .instructionOut(instructionOut), .PCOut(PCOut), .fifoCountOut(fifoCountOut),
        .fetch_state(fetch_state)
    );

    if_prefetch_stage #(.N(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .freezeIn(1'b0), .branchTakenIn(1'b0),
        .branchAddrIn(32'h0), .imemReqOut(w_req), .imemAddrOut(w_addr),
        .imemAckIn(w_ack), .imemDataIn(w_data), .validOut(w_valid),
        .instructionOut(w_instr), .PCOut(w_pc), .fifoCountOut(w_cnt),
        .fetch_state(w_state)
    );

`ifdef FETCH_BYPASS_EN
    localparam int EXP_LAT = 1;
`else
    localparam int EXP_LAT = 2;
`endif

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        fz, br, ack;
        logic [31:0] ba, d;
        logic        e_req, e_valid;
        logic [31:0] e_addr, e_instr, e_pc;
        logic [2:0]  e_cnt;
        logic [1:0]  e_st;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_words  = 0;
    int          lat_cnt  = 0;
    int          max_lat  = 0;
    logic        prev_fz  = 1'b0;
    logic        prev_br  = 1'b0;

    function automatic logic [31:0] mk_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic fz, input logic br, input logic [31:0] ba,
                           input logic ack, input logic [31:0] d,
                           input logic er, input logic [31:0] ea, input logic ev,
                           input logic [31:0] ei, input logic [31:0] ep,
                           input logic [2:0] ec, input logic [1:0] es);
        vec_t v;
        v.fz = fz; v.br = br; v.ba = ba; v.ack = ack; v.d = d;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei;
        v.e_pc = ep; v.e_cnt = ec; v.e_st = es;
        vecs.push_back(v);
    endtask

    // driver: one cycle with an auto-responding memory and the output monitor
    task automatic step(input logic fz, input logic br, input logic [31:0] ba);
        logic [63:0] e;
        @(negedge clk);
        if (!prev_fz && !prev_br) begin
            if (validOut) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_valid", {31'b0, validOut}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_instr", instructionOut, e[63:32]);
                    chk("sb_pc", PCOut, e[31:0]);
                    n_words++;
                end
            end else begin
                chk("sb_idle_instr", instructionOut, 32'h0);
            end
        end
        freezeIn      = fz;
        branchTakenIn = br;
        branchAddrIn  = ba;
        imemAckIn     = 1'b0;
        imemDataIn    = 32'h0;
        if (imemReqOut) begin
            if (lat_cnt == 0) begin
                imemAckIn  = 1'b1;
                imemDataIn = mk_data(imemAddrOut);
                if (!br) exp_q.push_back({mk_data(imemAddrOut), imemAddrOut + 32'd4});
                lat_cnt = $urandom_range(0, max_lat);
            end else begin
                lat_cnt--;
            end
        end
        if (br) exp_q.delete();
        prev_fz = fz;
        prev_br = br;
    endtask

    initial begin
        bit seen;
        int lat;

        freezeIn = 1'b0; branchTakenIn = 1'b0; branchAddrIn = 32'h0;
        imemAckIn = 1'b0; imemDataIn = 32'h0; w_ack = 1'b0; w_data = 32'h0;
        rst = 1'b1;

        //       fz    br    ba           ack   d             req   addr         vld   instr         pc           cnt   st
        add_vec(1'b0, 1'b0, 32'h0,       1'b1, 32'hA000_0000, 1'b1, 32'h0,       1'b0, 32'h0,        32'h0,       3'd0, 2'd1);
        add_vec(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 32'h0,        32'h0,       3'd1, 2'd0);
        add_vec(1'b0, 1'b0, 32'h0,       1'b1, 32'hA000_0001, 1'b1, 32'h4,       1'b1, 32'hA000_0000, 32'h4,       3'd0, 2'd1);
        add_vec(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 32'h0,        32'h0,       3'd1, 2'd0);
        add_vec(1'b0, 1'b0, 32'h0,       1'b1, 32'hA000_0002, 1'b1, 32'h8,       1'b1, 32'hA000_0001, 32'h8,       3'd0, 2'd1);
        add_vec(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 32'h0,        32'h0,       3'd1, 2'd0);
        add_vec(1'b1, 1'b0, 32'h0,       1'b1, 32'hA000_0003, 1'b1, 32'hC,       1'b1, 32'hA000_0002, 32'hC,       3'd0, 2'd1);
        add_vec(1'b1, 1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,       1'b1, 32'hA000_0002, 32'hC,       3'd1, 2'd0);
        add_vec(1'b1, 1'b0, 32'h0,       1'b1, 32'hA000_0004, 1'b1, 32'h10,      1'b1, 32'hA000_0002, 32'hC,       3'd1, 2'd1);
        add_vec(1'b1, 1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,       1'b1, 32'hA000_0002, 32'hC,       3'd2, 2'd0);
        add_vec(1'b1, 1'b0, 32'h0,       1'b1, 32'hA000_0005, 1'b1, 32'h14,      1'b1, 32'hA000_0002, 32'hC,       3'd2, 2'd1);
        add_vec(1'b1, 1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,       1'b1, 32'hA000_0002, 32'hC,       3'd3, 2'd0);
        add_vec(1'b1, 1'b0, 32'h0,       1'b1, 32'hA000_0006, 1'b1, 32'h18,      1'b1, 32'hA000_0002, 32'hC,       3'd3, 2'd1);
        add_vec(1'b1, 1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,       1'b1, 32'hA000_0002, 32'hC,       3'd4, 2'd0);
        add_vec(1'b1, 1'b0, 32'h0,       1'b1, 32'hBAD0_0000, 1'b0, 32'h0,       1'b1, 32'hA000_0002, 32'hC,       3'd4, 2'd0);
        add_vec(1'b1, 1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,       1'b1, 32'hA000_0002, 32'hC,       3'd4, 2'd0);
        add_vec(1'b1, 1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,       1'b1, 32'hA000_0002, 32'hC,       3'd4, 2'd0);
        add_vec(1'b1, 1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,       1'b1, 32'hA000_0002, 32'hC,       3'd4, 2'd0);
        add_vec(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,       1'b1, 32'hA000_0002, 32'hC,       3'd4, 2'd0);
        add_vec(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,       1'b1, 32'hA000_0003, 32'h10,      3'd3, 2'd0);
        add_vec(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 32'h1C,      1'b1, 32'hA000_0004, 32'h14,      3'd2, 2'd1);
        add_vec(1'b0, 1'b1, 32'h102,     1'b0, 32'h0,        1'b1, 32'h1C,      1'b1, 32'hA000_0005, 32'h18,      3'd1, 2'd1);
        add_vec(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 32'h1C,      1'b0, 32'h0,        32'h0,       3'd0, 2'd2);
        add_vec(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 32'h1C,      1'b0, 32'h0,        32'h0,       3'd0, 2'd2);
        add_vec(1'b0, 1'b0, 32'h0,       1'b1, 32'hDEAD_BEEF, 1'b1, 32'h1C,      1'b0, 32'h0,        32'h0,       3'd0, 2'd2);
        add_vec(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 32'h0,        32'h0,       3'd0, 2'd0);
        add_vec(1'b0, 1'b0, 32'h0,       1'b1, 32'hA000_0007, 1'b1, 32'h100,     1'b0, 32'h0,        32'h0,       3'd0, 2'd1);
        add_vec(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 32'h0,        32'h0,       3'd1, 2'd0);
        add_vec(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 32'h104,     1'b1, 32'hA000_0007, 32'h104,     3'd0, 2'd1);

        // reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'b0, imemReqOut}, 32'h0);
        chk("rst_valid", {31'b0, validOut}, 32'h0);
        chk("rst_instr", instructionOut, 32'h0);
        chk("rst_pc", PCOut, 32'h0);
        chk("rst_cnt", {29'b0, fifoCountOut}, 32'h0);
        chk("rst_wrap_req", {31'b0, w_req}, 32'h0);
        rst = 1'b0;

        // directed vector table
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            chk($sformatf("v%0d_req", i), {31'b0, imemReqOut}, {31'b0, vecs[i].e_req});
            if (vecs[i].e_req) chk($sformatf("v%0d_addr", i), imemAddrOut, vecs[i].e_addr);
            chk($sformatf("v%0d_valid", i), {31'b0, validOut}, {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d_instr", i), instructionOut, vecs[i].e_instr);
            chk($sformatf("v%0d_pc", i), PCOut, vecs[i].e_pc);
            chk($sformatf("v%0d_cnt", i), {29'b0, fifoCountOut}, {29'b0, vecs[i].e_cnt});
            chk($sformatf("v%0d_state", i), {30'b0, fetch_state}, {30'b0, vecs[i].e_st});
            freezeIn      = vecs[i].fz;
            branchTakenIn = vecs[i].br;
            branchAddrIn  = vecs[i].ba;
            imemAckIn     = vecs[i].ack;
            imemDataIn    = vecs[i].d;
        end

        // fill the FIFO under freeze, then branch with it full
        max_lat = 0;
        lat_cnt = 0;
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        repeat (12) step(1'b1, 1'b0, 32'h0);
        chk("full_cnt", {29'b0, fifoCountOut}, 32'd4);
        chk("full_req", {31'b0, imemReqOut}, 32'h0);
        chk("full_valid", {31'b0, validOut}, 32'h1);
        chk("full_instr", instructionOut, mk_data(32'h104));
        chk("full_pc", PCOut, 32'h108);
        step(1'b1, 1'b1, 32'h200);
        step(1'b1, 1'b0, 32'h0);
        chk("flush_cnt", {29'b0, fifoCountOut}, 32'h0);
        chk("flush_valid", {31'b0, validOut}, 32'h0);
        chk("flush_instr", instructionOut, 32'h0);
        for (int k = 0; k < 4 && !imemReqOut; k++) step(1'b0, 1'b0, 32'h0);
        chk("redirect_req", {31'b0, imemReqOut}, 32'h1);
        chk("redirect_addr", imemAddrOut, 32'h200);

        // random freeze and memory latency against the expected queue
        max_lat = 3;
        for (int k = 0; k < 60; k++) step(($urandom_range(0, 3) == 0), 1'b0, 32'h0);
        n_checks++;
        if (n_words < 8) begin
            n_errors++;
            $display("FAIL sb_words: got %0d expected at least 8", n_words);
        end
        n_checks++;
        if (exp_q.size() > 6) begin
            n_errors++;
            $display("FAIL sb_backlog: got %0d expected at most 6", exp_q.size());
        end

        // address wrap from RESET_PC=0xFFFFFFFC
        chk("wrap_req", {31'b0, w_req}, 32'h1);
        chk("wrap_addr", w_addr, 32'hFFFF_FFFC);
        chk("wrap_state", {30'b0, w_state}, 32'h1);
        w_ack = 1'b1;
        w_data = 32'h1234_5678;
        seen = 1'b0;
        lat = 0;
        for (int k = 1; k <= 4 && !seen; k++) begin
            @(negedge clk);
            w_ack = 1'b0;
            if (w_valid) begin
                seen = 1'b1;
                lat = k;
                chk("wrap_pc", w_pc, 32'h0);
                chk("wrap_instr", w_instr, 32'h1234_5678);
            end
        end
        chk("wrap_seen", {31'b0, seen}, 32'h1);
        chk("wrap_latency", lat, EXP_LAT);
        for (int k = 0; k < 4 && !w_req; k++) @(negedge clk);
        chk("wrap_next_req", {31'b0, w_req}, 32'h1);
        chk("wrap_next_addr", w_addr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
